// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, request kinds and immediate limits shared by the encoder
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_I    = 3'd1,
        KIND_S    = 3'd2,
        KIND_B    = 3'd3,
        KIND_U    = 3'd4,
        KIND_J    = 3'd5,
        KIND_LI   = 3'd6,
        KIND_RSVD = 3'd7
    } kind_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_LI_LO = 1'b1
    } state_e;

    localparam int signed IMM12_MIN = -2048;
    localparam int signed IMM12_MAX = 2047;
    localparam int signed IMMB_MIN  = -4096;
    localparam int signed IMMB_MAX  = 4094;
    localparam int signed IMMJ_MIN  = -1048576;
    localparam int signed IMMJ_MAX  = 1048574;

    function automatic logic fits_s12(input logic [31:0] v);
        return ($signed(v) >= IMM12_MIN) && ($signed(v) <= IMM12_MAX);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - request and instruction-word handshake bundle of the encoder
interface inst_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        inst_fault;
    logic        inst_last;

    modport slave (
        input  req_valid, req_kind, req_opcode, req_funct3, req_funct7,
        input  req_rd, req_rs1, req_rs2, req_imm, inst_ready,
        output req_ready, inst_valid, inst, inst_fault, inst_last
    );

    modport master (
        output req_valid, req_kind, req_opcode, req_funct3, req_funct7,
        output req_rd, req_rs1, req_rs2, req_imm, inst_ready,
        input  req_ready, inst_valid, inst, inst_fault, inst_last
    );
endinterface

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational RV32I field packer with immediate range check
module inst_pack
    import riscv_pkg::*;
(
    input  kind_e       i_kind,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_fault
);
    logic [31:0] w_raw;
    logic        w_range;

    always_comb begin
        w_raw   = 32'h0;
        w_range = 1'b0;
        case (i_kind)
            KIND_R: w_raw = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            KIND_I: begin
                w_range = !fits_s12(i_imm);
                w_raw   = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            end
            KIND_S: begin
                w_range = !fits_s12(i_imm);
                w_raw   = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            end
            KIND_B: begin
                w_range = i_imm[0] || ($signed(i_imm) < IMMB_MIN) || ($signed(i_imm) > IMMB_MAX);
                w_raw   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
            end
            KIND_U: begin
                w_range = (i_imm[11:0] != 12'h0);
                w_raw   = {i_imm[31:12], i_rd, i_opcode};
            end
            KIND_J: begin
                w_range = i_imm[0] || ($signed(i_imm) < IMMJ_MIN) || ($signed(i_imm) > IMMJ_MAX);
                w_raw   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            end
            // LI is expanded before packing, so reaching here as LI means reserved
            default: w_range = 1'b1;
        endcase
    end

    assign o_fault = w_range;
    assign o_word  = w_range ? 32'h0 : w_raw;
endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I encoder with LI expansion and a single-entry registered output
module inst_encoder
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    inst_encoder_if.slave  bus
);
    state_e      r_state, w_state_nxt;
    logic        r_valid, r_fault, r_last;
    logic [31:0] r_inst;
    logic [4:0]  r_li_rd;
    logic [11:0] r_li_lo;

    logic        w_valid_nxt, w_fault_nxt, w_last_nxt;
    logic [31:0] w_inst_nxt;
    logic        w_load, w_accept, w_is_li, w_li_pair;
    logic [31:0] w_li_hi;
    kind_e       w_req_kind;

    kind_e       w_p_kind;
    logic [6:0]  w_p_opcode, w_p_funct7;
    logic [2:0]  w_p_funct3;
    logic [4:0]  w_p_rd, w_p_rs1, w_p_rs2;
    logic [31:0] w_p_imm, w_word;
    logic        w_fault;

    assign w_req_kind    = kind_e'(bus.req_kind);
    assign w_load        = !r_valid || bus.inst_ready;
    assign bus.req_ready = !rst && (r_state == ST_IDLE) && w_load;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_is_li       = (w_req_kind == KIND_LI);
    assign w_li_pair     = !fits_s12(bus.req_imm) && (bus.req_imm[11:0] != 12'h0);
    // Rounding the upper part compensates for the sign-extended low 12 bits of the ADDI
    assign w_li_hi       = (bus.req_imm + 32'h0000_0800) & 32'hFFFF_F000;

    always_comb begin
        w_p_kind   = w_req_kind;
        w_p_opcode = bus.req_opcode;
        w_p_funct3 = bus.req_funct3;
        w_p_funct7 = bus.req_funct7;
        w_p_rd     = bus.req_rd;
        w_p_rs1    = bus.req_rs1;
        w_p_rs2    = bus.req_rs2;
        w_p_imm    = bus.req_imm;
        if (r_state == ST_LI_LO) begin
            w_p_kind   = KIND_I;
            w_p_opcode = OPC_OP_IMM;
            w_p_funct3 = 3'd0;
            w_p_funct7 = 7'd0;
            w_p_rd     = r_li_rd;
            w_p_rs1    = r_li_rd;
            w_p_rs2    = 5'd0;
            w_p_imm    = {{20{r_li_lo[11]}}, r_li_lo};
        end else if (w_is_li) begin
            w_p_funct3 = 3'd0;
            w_p_funct7 = 7'd0;
            w_p_rs1    = 5'd0;
            w_p_rs2    = 5'd0;
            if (fits_s12(bus.req_imm)) begin
                w_p_kind   = KIND_I;
                w_p_opcode = OPC_OP_IMM;
            end else begin
                w_p_kind   = KIND_U;
                w_p_opcode = OPC_LUI;
                w_p_imm    = w_li_pair ? w_li_hi : bus.req_imm;
            end
        end
    end

    inst_pack u_pack (
        .i_kind   (w_p_kind),
        .i_opcode (w_p_opcode),
        .i_funct3 (w_p_funct3),
        .i_funct7 (w_p_funct7),
        .i_rd     (w_p_rd),
        .i_rs1    (w_p_rs1),
        .i_rs2    (w_p_rs2),
        .i_imm    (w_p_imm),
        .o_word   (w_word),
        .o_fault  (w_fault)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_inst_nxt  = r_inst;
        w_fault_nxt = r_fault;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_valid_nxt = 1'b1;
                    w_inst_nxt  = w_word;
                    w_fault_nxt = w_fault;
                    w_last_nxt  = !(w_is_li && w_li_pair);
                    if (w_is_li && w_li_pair)
                        w_state_nxt = ST_LI_LO;
                end else if (w_load) begin
                    w_valid_nxt = 1'b0;
                end
            end
            ST_LI_LO: begin
                if (w_load) begin
                    w_valid_nxt = 1'b1;
                    w_inst_nxt  = w_word;
                    w_fault_nxt = w_fault;
                    w_last_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_inst  <= 32'h0;
            r_fault <= 1'b0;
            r_last  <= 1'b0;
            r_li_rd <= 5'd0;
            r_li_lo <= 12'h0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_inst  <= w_inst_nxt;
            r_fault <= w_fault_nxt;
            r_last  <= w_last_nxt;
            if (r_state == ST_IDLE && w_accept) begin
                r_li_rd <= bus.req_rd;
                r_li_lo <= bus.req_imm[11:0];
            end
        end
    end

    assign bus.inst_valid = r_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_fault = r_fault;
    assign bus.inst_last  = r_last;
endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed bench for inst_encoder with hand-computed words
module tb_inst_encoder;
    logic clk = 1'b0;
    logic rst;
    int   n_err = 0;
    int   n_chk = 0;

    inst_encoder_if bus ();

    inst_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] w, input logic f, input logic l);
        chk({tag, ".valid"}, {31'd0, bus.inst_valid}, 32'd1);
        chk({tag, ".inst"},  bus.inst, w);
        chk({tag, ".fault"}, {31'd0, bus.inst_fault}, {31'd0, f});
        chk({tag, ".last"},  {31'd0, bus.inst_last}, {31'd0, l});
    endtask

    task automatic set_req(input logic [2:0] k, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        bus.req_kind   = k;
        bus.req_opcode = op;
        bus.req_funct3 = f3;
        bus.req_funct7 = f7;
        bus.req_rd     = rd;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_imm    = imm;
        bus.req_valid  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus.inst_ready = 1'b1;
        set_req(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        bus.req_valid = 1'b0;
        step();
        step();
        chk("rst.req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst.valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst.inst", bus.inst, 32'd0);
        chk("rst.fault", {31'd0, bus.inst_fault}, 32'd0);
        chk("rst.last", {31'd0, bus.inst_last}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle.req_ready", {31'd0, bus.req_ready}, 32'd1);

        // ADD x3,x1,x2, then the output empties when popped with no new request
        set_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        bus.req_valid = 1'b0;
        chk_word("add", 32'h002081B3, 1'b0, 1'b1);
        step();
        chk("add.drain", {31'd0, bus.inst_valid}, 32'd0);

        // back-to-back single-word requests
        set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        step();
        chk_word("addi_m1", 32'hFFF00093, 1'b0, 1'b1);
        chk("b2b.req_ready", {31'd0, bus.req_ready}, 32'd1);
        set_req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        step();
        chk_word("beq8", 32'h00208463, 1'b0, 1'b1);
        set_req(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4);
        step();
        chk_word("sw4", 32'h0020A223, 1'b0, 1'b1);
        set_req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        step();
        chk_word("jal2048", 32'h001000EF, 1'b0, 1'b1);
        set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
        step();
        bus.req_valid = 1'b0;
        chk_word("addi_min", 32'h80000093, 1'b0, 1'b1);
        step();

        // LI pair
        set_req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        step();
        bus.req_valid = 1'b0;
        chk_word("li_lui", 32'h123462B7, 1'b0, 1'b0);
        chk("li_lo.req_ready", {31'd0, bus.req_ready}, 32'd0);
        step();
        chk_word("li_addi", 32'hFFF28293, 1'b0, 1'b1);
        chk("li_done.req_ready", {31'd0, bus.req_ready}, 32'd1);

        // single-word LI forms
        set_req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00001000);
        step();
        chk_word("li_lui_only", 32'h000012B7, 1'b0, 1'b1);
        chk("li1.req_ready", {31'd0, bus.req_ready}, 32'd1);
        set_req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFB);
        step();
        chk_word("li_m5", 32'hFFB00293, 1'b0, 1'b1);

        // faults, then normal encoding resumes
        set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        step();
        chk_word("f_addi2048", 32'h0, 1'b1, 1'b1);
        set_req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        step();
        chk_word("f_beq3", 32'h0, 1'b1, 1'b1);
        set_req(3'd7, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        chk_word("f_rsvd", 32'h0, 1'b1, 1'b1);
        set_req(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00001001);
        step();
        chk_word("f_lui_lo", 32'h0, 1'b1, 1'b1);
        set_req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        step();
        chk_word("f_jal_odd", 32'h0, 1'b1, 1'b1);
        set_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        bus.req_valid = 1'b0;
        chk_word("add_after_fault", 32'h002081B3, 1'b0, 1'b1);
        step();

        // backpressure on the LUI of a pair
        bus.inst_ready = 1'b0;
        set_req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        step();
        bus.req_valid = 1'b0;
        chk_word("bp_lui", 32'h123462B7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_word("bp_hold", 32'h123462B7, 1'b0, 1'b0);
            chk("bp.req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.inst_ready = 1'b1;
        #1;
        chk("bp_lilo.req_ready", {31'd0, bus.req_ready}, 32'd0);
        step();
        chk_word("bp_addi", 32'hFFF28293, 1'b0, 1'b1);
        step();
        chk("bp.drain", {31'd0, bus.inst_valid}, 32'd0);

        // reset while the ADDI is pending
        bus.inst_ready = 1'b0;
        set_req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        step();
        bus.req_valid = 1'b0;
        chk_word("rst_lui", 32'h123462B7, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid.req_ready", {31'd0, bus.req_ready}, 32'd0);
        step();
        chk("rst_mid.valid", {31'd0, bus.inst_valid}, 32'd0);
        rst = 1'b0;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_addi", {31'd0, bus.inst_valid}, 32'd0);
        end
        set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        step();
        bus.req_valid = 1'b0;
        chk_word("post_rst_addi", 32'hFFF00093, 1'b0, 1'b1);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
